// File: rtl/spi_read_responder.sv
// spi_read_responder: SPI mode-0 read-path responder sharing the 16-bit frame
// format with the write receiver. Decodes {R/W, addr[6:0]} during the first
// eight rising edges. A read snapshots the addressed register at edge 8 and
// shifts it out MSB first on cipo, launched on falling edges.
// Ports: rst_n (async active-low reset), sclk (SPI clock), cs_n (active-low
//        select, async frame abort), copi (serial in), reg_0..reg_4 (register
//        values), cipo/cipo_oe (serial out + pad enable), addr_err (last read
//        was out of range).
module spi_read_responder #(
    parameter int NUM_REGS = 5
) (
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       copi,
    input  logic [7:0] reg_0,
    input  logic [7:0] reg_1,
    input  logic [7:0] reg_2,
    input  logic [7:0] reg_3,
    input  logic [7:0] reg_4,
    output logic       cipo,
    output logic       cipo_oe,
    output logic       addr_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        DATA = 3'd2,
        SKIP = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [7:0] NUM_REGS_L = 8'(NUM_REGS);

    state_t     state;
    logic [4:0] cnt;
    logic [7:0] cmd;
    logic [7:0] snap;

    // Frame-scoped state is cleared by either reset or a deasserted select;
    // snap and addr_err only respond to the real reset so they survive frames.
    logic frame_rst_n;
    assign frame_rst_n = rst_n & ~cs_n;

    // Command byte as it will look after the current rising edge; at edge 8
    // this holds the complete {R/W, addr} pair.
    logic [7:0] cmd_next;
    logic [6:0] addr_next;
    logic       in_range;
    logic       cmd_done;
    logic [7:0] reg_sel;

    assign cmd_next  = {cmd[6:0], copi};
    assign addr_next = cmd_next[6:0];
    // Range check uses all 7 address bits; the mux below only the low 3.
    assign in_range  = ({1'b0, addr_next} < NUM_REGS_L);
    assign cmd_done  = (state == CMD) && (cnt == 5'd7);

    always_comb begin
        reg_sel = 8'h00;
        case (addr_next[2:0])
            3'd0:    reg_sel = reg_0;
            3'd1:    reg_sel = reg_1;
            3'd2:    reg_sel = reg_2;
            3'd3:    reg_sel = reg_3;
            3'd4:    reg_sel = reg_4;
            default: reg_sel = 8'h00;
        endcase
    end

    // Rising-edge frame FSM: counts edges and collects the command.
    always_ff @(posedge sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            state <= IDLE;
            cnt   <= 5'd0;
            cmd   <= 8'h00;
        end else begin
            if (cnt != 5'd16) begin
                cnt <= cnt + 5'd1;
            end
            case (state)
                IDLE: begin
                    cmd   <= cmd_next;
                    state <= CMD;
                end
                CMD: begin
                    cmd <= cmd_next;
                    if (cnt == 5'd7) begin
                        state <= cmd_next[7] ? SKIP : DATA;
                    end
                end
                DATA, SKIP: begin
                    if (cnt == 5'd15) begin
                        state <= DONE;
                    end
                end
                default: state <= DONE;
            endcase
        end
    end

    // Read snapshot and error flag, captured only at edge 8 of a read so the
    // outgoing byte is immune to later register changes.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            snap     <= 8'h00;
            addr_err <= 1'b0;
        end else if (cmd_done && !cmd_next[7]) begin
            snap     <= in_range ? reg_sel : 8'h00;
            addr_err <= ~in_range;
        end
    end

    // Falling-edge launch: during DATA cnt runs 8..15, so ~cnt[2:0] walks
    // the snapshot from bit 7 down to bit 0.
    always_ff @(negedge sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            cipo    <= 1'b0;
            cipo_oe <= 1'b0;
        end else if (state == DATA) begin
            cipo    <= snap[~cnt[2:0]];
            cipo_oe <= 1'b1;
        end else begin
            cipo    <= 1'b0;
            cipo_oe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_read_responder.sv
// tb_spi_read_responder: drives SPI frames into spi_read_responder and checks
// received read bytes, output-enable window and addr_err against a
// register-array model through an expected-frame queue.
module tb_spi_read_responder;

    localparam int NUM_REGS = 5;

    logic       rst_n = 1'b0;
    logic       sclk  = 1'b0;
    logic       cs_n  = 1'b1;
    logic       copi  = 1'b0;
    logic [7:0] regv [NUM_REGS];
    logic       cipo;
    logic       cipo_oe;
    logic       addr_err;

    spi_read_responder #(.NUM_REGS(NUM_REGS)) dut (
        .rst_n    (rst_n),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .copi     (copi),
        .reg_0    (regv[0]),
        .reg_1    (regv[1]),
        .reg_2    (regv[2]),
        .reg_3    (regv[3]),
        .reg_4    (regv[4]),
        .cipo     (cipo),
        .cipo_oe  (cipo_oe),
        .addr_err (addr_err)
    );

    typedef struct {
        logic [7:0] val;
        int         nbits;
        logic       err;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    logic m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: shift in cipo while the pad is enabled, sampled in the high
    // phase after each rising edge, exactly as the controller would.
    int         rx_n = 0;
    logic [7:0] rx   = 8'h00;

    always @(posedge sclk) begin
        #1;
        if (mon_en && !cs_n && cipo_oe === 1'b1) begin
            rx   = {rx[6:0], cipo};
            rx_n = rx_n + 1;
        end
    end

    always @(posedge cs_n) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_oe_bits"}, rx_n, e.nbits);
                if (e.nbits > 0 && rx_n == e.nbits) begin
                    chk({e.name, "_data"}, 32'(rx) & ((32'd1 << rx_n) - 1),
                        32'(e.val) >> (8 - e.nbits));
                end
                chk({e.name, "_addr_err"}, 32'(addr_err), 32'(e.err));
            end
        end
        rx_n = 0;
        rx   = 8'h00;
    end

    // One frame: computes the expected outcome from the register array and
    // frame rules, queues it, then drives the pins.
    task automatic run_frame(input string name, input logic [15:0] word, input int edges,
                             input int chg_edge, input int chg_idx, input logic [7:0] chg_val,
                             input bit rst_pulse);
        exp_t       e;
        logic [6:0] a;
        bit         rd;
        a       = word[14:8];
        rd      = !word[15];
        e.name  = name;
        e.val   = 8'h00;
        e.nbits = 0;
        if (rd && edges >= 8) begin
            e.val   = (int'(a) < NUM_REGS) ? regv[a] : 8'h00;
            m_err   = (int'(a) >= NUM_REGS);
            e.nbits = (edges >= 16) ? 8 : edges - 8;
        end
        if (rst_pulse) begin
            m_err = 1'b0;
        end
        e.err = m_err;
        exp_q.push_back(e);

        cs_n = 1'b0;
        #5;
        for (int i = 0; i < edges; i++) begin
            copi = (i < 16) ? word[15 - i] : 1'($urandom);
            #5 sclk = 1'b1;
            #5 sclk = 1'b0;
            if (i + 1 == chg_edge) begin
                regv[chg_idx] = chg_val;
            end
        end
        #2;
        if (rst_pulse) begin
            rst_n = 1'b0;
            #1;
            chk({name, "_rst_cipo"}, 32'(cipo), 32'd0);
            chk({name, "_rst_oe"}, 32'(cipo_oe), 32'd0);
            chk({name, "_rst_err"}, 32'(addr_err), 32'd0);
            #2 rst_n = 1'b1;
        end
        cs_n = 1'b1;
        #1;
        chk({name, "_end_oe"}, 32'(cipo_oe), 32'd0);
        chk({name, "_end_cipo"}, 32'(cipo), 32'd0);
        #6;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        regv[0] = 8'h5A; regv[1] = 8'h11; regv[2] = 8'hA5;
        regv[3] = 8'hC3; regv[4] = 8'h3C;
        #3;
        chk("reset_cipo", 32'(cipo), 32'd0);
        chk("reset_oe", 32'(cipo_oe), 32'd0);
        chk("reset_err", 32'(addr_err), 32'd0);
        #4 rst_n = 1'b1;
        #5 mon_en = 1'b1;

        // Directed cases.
        run_frame("rd_a2", 16'h02_00, 16, 0, 0, 8'h00, 1'b0);
        run_frame("rd_a4_change", 16'h04_00, 16, 11, 4, 8'hFF, 1'b0);
        run_frame("rd_a5_err", 16'h05_00, 16, 0, 0, 8'h00, 1'b0);
        run_frame("wr_a1_keeps_err", 16'h81_77, 16, 0, 0, 8'h00, 1'b0);
        run_frame("rd_a1_clear", 16'h01_00, 16, 0, 0, 8'h00, 1'b0);
        run_frame("rd_a3_abort12", 16'h03_00, 12, 0, 0, 8'h00, 1'b0);
        run_frame("rd_a0_after_abort", 16'h00_00, 16, 0, 0, 8'h00, 1'b0);
        run_frame("rd_a0_20edges", 16'h00_00, 20, 0, 0, 8'h00, 1'b0);
        run_frame("rd_a41_high_bits", 16'h41_00, 16, 0, 0, 8'h00, 1'b0);
        run_frame("rd_a2_abort5", 16'h02_00, 5, 0, 0, 8'h00, 1'b0);
        run_frame("rd_a3_rst10", 16'h03_00, 10, 0, 0, 8'h00, 1'b1);
        run_frame("rd_a2_after_rst", 16'h02_00, 16, 0, 0, 8'h00, 1'b0);

        // Randomised frames.
        for (int n = 0; n < 40; n++) begin
            logic [6:0]  a;
            logic [15:0] w;
            int          ed;
            int          sel;
            for (int r = 0; r < NUM_REGS; r++) begin
                regv[r] = 8'($urandom);
            end
            sel = $urandom_range(0, 9);
            a   = (sel < 7) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(0, 127));
            w   = {1'($urandom_range(0, 3) == 0), a, 8'($urandom)};
            sel = $urandom_range(0, 9);
            ed  = (sel < 6) ? 16 : (sel < 8) ? $urandom_range(17, 22) : $urandom_range(1, 15);
            run_frame("rand", w, ed, $urandom_range(9, 16), $urandom_range(0, NUM_REGS - 1),
                      8'($urandom), 1'b0);
        end

        #5;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
